// File: rtl/seg_scan_sched_if.sv
// Handshake and display-control bundle between the digit-scan scheduler and
// its surroundings (enable/blink control in, digit select and serializer load out).
interface seg_scan_sched_if;
  logic       en;
  logic [5:0] blink_mask;
  logic       ld_busy;
  logic       ovr_clr;
  logic [5:0] sel;
  logic [2:0] digit_idx;
  logic       ld_start;
  logic       blank;
  logic       frame_done;
  logic       overrun;

  modport master (
    output en, blink_mask, ld_busy, ovr_clr,
    input  sel, digit_idx, ld_start, blank, frame_done, overrun
  );

  modport slave (
    input  en, blink_mask, ld_busy, ovr_clr,
    output sel, digit_idx, ld_start, blank, frame_done, overrun
  );
endinterface

// File: rtl/seg_scan_sched.sv
// Six-digit scan scheduler: one-hot digit walk with fixed dwell, one serializer
// load per digit, blink phase generation, frame pulse and sticky overrun flag.
module seg_scan_sched #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DIGIT_US = 1000,
  parameter int BLINK_MS = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_sched_if.slave bus
);

  localparam int DW  = CLK_HZ / 1_000_000 * DIGIT_US;
  localparam int BW  = CLK_HZ / 1000 * BLINK_MS;
  localparam int DCW = (DW > 1) ? $clog2(DW) : 1;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [DCW-1:0] DW_LAST = DCW'(DW - 1);
  localparam logic [BCW-1:0] BW_LAST = BCW'(BW - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_DWELL   = 2'd2;
  localparam logic [1:0] S_ADVANCE = 2'd3;

  localparam logic [5:0] SEL_FIRST = 6'b000001;
  localparam logic [2:0] IDX_LAST  = 3'd5;

  logic [1:0]     state_q, state_d;
  logic [5:0]     sel_q, sel_d;
  logic [2:0]     idx_q, idx_d;
  logic           ld_start_q, ld_start_d;
  logic           blank_q, blank_d;
  logic           frame_done_q, frame_done_d;
  logic           overrun_q, overrun_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           phase_q, phase_d;
  logic           ovr_set;

  // NOTE: every signal driven here gets a default first, so no path can hold
  // a stale value and infer a latch.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    idx_d        = idx_q;
    ld_start_d   = 1'b0;
    blank_d      = blank_q;
    frame_done_d = 1'b0;
    dcnt_d       = dcnt_q;
    ovr_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d   = '0;
        idx_d   = '0;
        blank_d = 1'b0;
        if (bus.en) begin
          state_d = S_ISSUE;
          sel_d   = SEL_FIRST;
        end
      end

      S_ISSUE: begin
        if (!bus.ld_busy) begin
          state_d    = S_DWELL;
          ld_start_d = 1'b1;
          dcnt_d     = '0;
          // sel is one-hot on idx, so masking with it picks blink_mask[idx].
          blank_d    = phase_q & |(bus.blink_mask & sel_q);
        end
      end

      S_DWELL: begin
        if (dcnt_q == DW_LAST) begin
          state_d = S_ADVANCE;
          ovr_set = bus.ld_busy;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: begin
        frame_done_d = (idx_q == IDX_LAST);
        if (bus.en) begin
          state_d = S_ISSUE;
          idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          sel_d   = {sel_q[4:0], sel_q[5]};
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
          sel_d   = '0;
          blank_d = 1'b0;
        end
      end
    endcase
  end

  // Blink counter only runs while scanning is enabled; disabling parks it at phase 0.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!bus.en) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BW_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // A new overrun in the same cycle as a clear must survive.
  assign overrun_d = ovr_set | (overrun_q & ~bus.ovr_clr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      idx_q        <= '0;
      ld_start_q   <= 1'b0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      dcnt_q       <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      ld_start_q   <= ld_start_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      dcnt_q       <= dcnt_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.digit_idx  = idx_q;
  assign bus.ld_start   = ld_start_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with DW=4 (digit period 6) and BW=1000.
module tb_seg_scan_sched;

  logic clk = 1'b0;
  logic rst;
  seg_scan_sched_if bus ();

  seg_scan_sched #(
    .CLK_HZ  (1_000_000),
    .DIGIT_US(4),
    .BLINK_MS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       busy;
    logic [5:0] sel;
    logic [2:0] idx;
    logic       ld;
    logic       blank;
    logic       fd;
    logic       ovr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout at cycle %0d", nm, cyc);
  endtask

  task automatic wait_sel(input logic [5:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.sel == target) return;
    end
    timeout("wait_sel");
  endtask

  task automatic wait_ld(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.ld_start) return;
    end
    timeout("wait_ld");
  endtask

  int last_ld, exp_digit, next_fd, nld, nfd, t_d2, blank_hits, blank_misses;
  logic exp_blank;

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.blink_mask = 6'b0;
    bus.ld_busy = 1'b0;
    bus.ovr_clr = 1'b0;

    //         rst   en    busy  sel        idx   ld    blank fd    ovr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'b000010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      bus.en = vecs[i].en;
      bus.ld_busy = vecs[i].busy;
      tick();
      if (vecs[i].rst) cyc = 0;
      check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_idx", i), 32'(bus.digit_idx), 32'(vecs[i].idx));
      check($sformatf("vec%0d_ld", i), 32'(bus.ld_start), 32'(vecs[i].ld));
      check($sformatf("vec%0d_blank", i), 32'(bus.blank), 32'(vecs[i].blank));
      check($sformatf("vec%0d_fd", i), 32'(bus.frame_done), 32'(vecs[i].fd));
      check($sformatf("vec%0d_ovr", i), 32'(bus.overrun), 32'(vecs[i].ovr));
    end

    // Free-running scan: ld_start every 6 cycles, frame_done every 36.
    last_ld = cyc; exp_digit = 2; next_fd = 37; nld = 0; nfd = 0;
    while (cyc < 80) begin
      tick();
      if (bus.ld_start) begin
        check("ld_spacing", 32'(cyc - last_ld), 32'd6);
        check("ld_sel", 32'(bus.sel), 32'(6'b1 << exp_digit));
        last_ld = cyc;
        exp_digit = (exp_digit + 1) % 6;
        nld++;
      end
      if (bus.frame_done) begin
        check("fd_time", 32'(cyc), 32'(next_fd));
        check("fd_sel_wrap", 32'(bus.sel), 32'(6'b000001));
        next_fd += 36;
        nfd++;
      end
    end
    check("ld_count", 32'(nld), 32'd12);
    check("fd_count", 32'(nfd), 32'd2);

    // Busy stall on digit 2 entry: three extra ISSUE cycles.
    wait_sel(6'b000100, 20);
    t_d2 = cyc;
    bus.ld_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_ld", 32'(bus.ld_start), 32'd0);
    end
    bus.ld_busy = 1'b0;
    tick();
    check("stall_ld", 32'(bus.ld_start), 32'd1);
    check("stall_ld_delay", 32'(cyc - t_d2), 32'd4);
    wait_sel(6'b001000, 20);
    check("stall_period", 32'(cyc - t_d2), 32'd9);
    check("stall_no_ovr", 32'(bus.overrun), 32'd0);

    // Overrun: busy raised at count 0 of digit 1, held past the dwell.
    wait_sel(6'b000010, 40);
    wait_ld(10);
    bus.ld_busy = 1'b1;
    tick(); tick(); tick();
    check("ovr_before_end", 32'(bus.overrun), 32'd0);
    tick();
    check("ovr_set", 32'(bus.overrun), 32'd1);
    tick();
    check("ovr_next_sel", 32'(bus.sel), 32'(6'b000100));
    tick();
    check("ovr_issue_wait", 32'(bus.ld_start), 32'd0);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    bus.ld_busy = 1'b0;
    tick();
    check("ovr_issue_ld", 32'(bus.ld_start), 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    check("ovr_clear", 32'(bus.overrun), 32'd0);
    bus.ovr_clr = 1'b0;
    bus.ld_busy = 1'b1;
    tick(); tick();
    bus.ovr_clr = 1'b1;
    tick();
    check("ovr_set_wins", 32'(bus.overrun), 32'd1);
    bus.ld_busy = 1'b0;
    tick();
    check("ovr_clear2", 32'(bus.overrun), 32'd0);
    bus.ovr_clr = 1'b0;

    // Blink: only digit 2 blanks, and only in phase 1 (cycles 1000..1999 since reset).
    bus.blink_mask = 6'b000100;
    blank_hits = 0; blank_misses = 0;
    while (cyc < 2100) begin
      tick();
      if (bus.ld_start) begin
        exp_blank = (bus.sel == 6'b000100) && ((((cyc - 1) / 1000) % 2) == 1);
        check("blank", 32'(bus.blank), 32'(exp_blank));
        if (bus.sel == 6'b000100) begin
          if (bus.blank) blank_hits++;
          else blank_misses++;
        end
      end
    end
    check("blank_seen_on", 32'(blank_hits > 0), 32'd1);
    check("blank_seen_off", 32'(blank_misses > 0), 32'd1);
    bus.blink_mask = 6'b0;

    // Disable during digit 3 dwell: dwell completes, ADVANCE, then IDLE.
    wait_sel(6'b001000, 40);
    wait_ld(10);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dis_hold_sel", 32'(bus.sel), 32'(6'b001000));
    end
    tick();
    check("dis_idle_sel", 32'(bus.sel), 32'd0);
    check("dis_idle_idx", 32'(bus.digit_idx), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_no_ld", 32'(bus.ld_start), 32'd0);
    end

    // Reset mid-dwell with overrun pending.
    bus.en = 1'b1;
    tick();
    check("rs_issue_sel", 32'(bus.sel), 32'(6'b000001));
    tick();
    check("rs_ld", 32'(bus.ld_start), 32'd1);
    bus.ld_busy = 1'b1;
    tick(); tick(); tick(); tick();
    check("rs_ovr", 32'(bus.overrun), 32'd1);
    bus.ld_busy = 1'b0;
    tick(); tick();
    check("rs_ld2", 32'(bus.ld_start), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rs_sel", 32'(bus.sel), 32'd0);
    check("rs_idx", 32'(bus.digit_idx), 32'd0);
    check("rs_ld0", 32'(bus.ld_start), 32'd0);
    check("rs_ovr0", 32'(bus.overrun), 32'd0);
    check("rs_blank0", 32'(bus.blank), 32'd0);
    rst = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rs_no_ld", 32'(bus.ld_start), 32'd0);
      check("rs_idle_sel", 32'(bus.sel), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
